parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
- Downstream consumer of the parity generator stage: receives a serial frame of DATA_W data bits followed by one parity bit.
- Reassembles the data word and checks the parity bit against the selected even/odd mode.
- Flags each mismatch and keeps a saturating error count for status/debug.

Parameters:
- DATA_W, 3, number of data bits per frame, sent MSB first.
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  frame start; asserted in the same cycle as the first (MSB) data bit on din.
- din  input  1  serial data/parity bit, sampled every cycle while the frame is active.
- odd_mode  input  1  parity mode: 0 = even, 1 = odd. Sampled only on the accepted start cycle.
- data_out  output  DATA_W  last completed data word.
- data_valid  output  1  one-cycle pulse when a frame completes.
- par_err  output  1  one-cycle pulse, coincident with data_valid, when the parity check fails.
- err_count  output  CNT_W  saturating count of failed frames.
- busy  output  1  high while a frame is in progress after start.

Behaviour:
- Reset: synchronous on rising clk edge with rst=1. Reset values:
  - FSM = IDLE
  - data_out = 0, data_valid = 0, par_err = 0, err_count = 0, busy = 0
  - shift register, bit counter and latched mode cleared
  - rst has priority over all other inputs.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - start=1: shift din into bit 0 of the shift register, latch odd_mode, set bit counter = 1.
  - Next state: DATA if DATA_W>1, else PARITY. busy=1 from the next cycle.
  - start=0: stay in IDLE; din is ignored.
- DATA:
  - Each cycle, shift din in (shreg <= {shreg[DATA_W-2:0], din}) and increment the counter.
  - When the counter reaches DATA_W, go to PARITY.
- PARITY:
  - Sample din as the received parity bit p.
  - Expected parity: e = ^shreg XOR latched odd_mode. Even mode: p must equal the XOR of the data bits. Odd mode: p must equal its inverse.
  - On the same edge, register the outputs: data_out <= shreg, data_valid <= 1, par_err <= (p != e).
  - If p != e and err_count is not all ones, increment err_count.
  - Next state: IDLE, busy <= 0.
- Latency: data_valid rises in the cycle after the parity bit is on din. This is DATA_W+1 cycles after the start cycle.
- data_valid and par_err are high for exactly one cycle. data_out holds its value until the next frame completes.
- err_count saturates at 2^CNT_W-1 and never wraps. It is cleared only by rst.
- start while busy (DATA/PARITY) is ignored and does not restart the frame.
- Back-to-back frames: start is accepted in the cycle data_valid is high (FSM already in IDLE), giving zero idle cycles between frames.
- Reset mid-frame: the frame is discarded. No data_valid and no count update. The FSM restarts in IDLE on the next cycle.
- odd_mode changes mid-frame have no effect on the current frame.

Test Plan:
- Even mode, DATA_W=3: start + din = 1,1,1, then parity 1 -> data_valid pulse 4 cycles after start, data_out=111, par_err=0, err_count=0.
- Odd mode: din = 0,1,1, then parity 1 -> data_out=011, par_err=0. Repeat with parity 0 -> par_err=1, err_count=1.
- Even mode: din = 1,0,1, then parity 1 (expected 0) -> data_out=101, par_err=1, err_count increments by 1. Next good frame 001/1 -> par_err=0, count unchanged.
- Saturation with CNT_W=2: five consecutive bad frames -> err_count sequence 1,2,3,3,3, with a par_err pulse every frame.
- Interference mid-frame:
  - start pulse during DATA -> ignored, original frame completes with the correct data_out.
  - rst asserted after 2 data bits -> no data_valid, all outputs 0.
  - A new frame afterwards completes normally.
- Back-to-back: second start in the data_valid cycle of the first frame -> two data_valid pulses exactly 4 cycles apart, both words correct.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: reassembles DATA_W data bits (MSB first) and checks
// the trailing parity bit, flagging mismatches and counting them (saturating).
module parity_frame_checker #(
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din,
    input  logic              odd_mode,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              par_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] r_data_out;
    logic [CW-1:0]     r_cnt;
    logic              r_mode;
    logic              r_data_valid;
    logic              r_par_err;
    logic [CNT_W-1:0]  r_err_count;

    logic [DATA_W:0]   w_shift;
    logic              w_last;
    logic              w_mismatch;

    assign w_shift    = {r_shreg, din};
    assign w_last     = (r_cnt == CW'(DATA_W - 1));
    assign w_mismatch = (din != (^r_shreg ^ r_mode));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (DATA_W > 1) ? S_DATA : S_PARITY;
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_next = S_PARITY;
                end
            end
            S_PARITY: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg      <= '0;
            r_data_out   <= '0;
            r_cnt        <= '0;
            r_mode       <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg <= DATA_W'(din);
                        r_mode  <= odd_mode;
                        r_cnt   <= CW'(1);
                    end
                end
                S_DATA: begin
                    r_shreg <= w_shift[DATA_W-1:0];
                    r_cnt   <= r_cnt + CW'(1);
                end
                S_PARITY: begin
                    r_data_out   <= r_shreg;
                    r_data_valid <= 1'b1;
                    r_par_err    <= w_mismatch;
                    r_cnt        <= '0;
                    // Saturate rather than wrap so a stuck link stays visible
                    if (w_mismatch && !(&r_err_count)) begin
                        r_err_count <= r_err_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign err_count  = r_err_count;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench for parity_frame_checker: directed frames, saturation,
// mid-frame interference, back-to-back and randomized traffic.
module tb_parity_frame_checker;

    localparam int DATA_W = 3;
    localparam int CNT_W  = 2;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              start;
    logic              din;
    logic              odd_mode;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              par_err;
    logic [CNT_W-1:0]  err_count;
    logic              busy;

    typedef struct {
        int data;
        int perr;
        int cnt;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;

    parity_frame_checker #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .odd_mode  (odd_mode),
        .data_out  (data_out),
        .data_valid(data_valid),
        .par_err   (par_err),
        .err_count (err_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per completed frame
    always @(negedge clk) begin
        exp_t e;
        chk("perr_without_valid", int'(par_err & ~data_valid), 0);
        if (data_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("data_out", int'(data_out), e.data);
                chk("par_err", int'(par_err), e.perr);
                chk("err_count", int'(err_count), e.cnt);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start    = 1'b0;
            din      = 1'($urandom);
            odd_mode = 1'($urandom);
        end
    endtask

    // Reference: count of ones in data plus parity must be even (even mode)
    // or odd (odd mode); otherwise the frame is an error.
    task automatic send_frame(input int data, input int odd,
                              input int par, input int inj);
        exp_t e;
        int   ones;
        int   bad;
        ones = $countones(data & ((1 << DATA_W) - 1));
        bad  = ((ones + par) % 2) != odd;
        if (bad != 0 && model_cnt < SAT) model_cnt++;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            @(negedge clk);
            if (i == DATA_W - 1) begin
                start    = 1'b1;
                odd_mode = 1'(odd);
                e.data   = data & ((1 << DATA_W) - 1);
                e.perr   = bad;
                e.cnt    = model_cnt;
                e.cyc    = cyc + DATA_W + 1;
                q.push_back(e);
            end else begin
                start    = (inj != 0) ? 1'($urandom) : 1'b0;
                odd_mode = 1'($urandom);
            end
            din = 1'((data >> i) & 1);
        end
        @(negedge clk);
        start    = (inj != 0) ? 1'($urandom) : 1'b0;
        odd_mode = 1'($urandom);
        din      = 1'(par);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_data_out"}, int'(data_out), 0);
        chk({tag, "_data_valid"}, int'(data_valid), 0);
        chk({tag, "_par_err"}, int'(par_err), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        check_cleared("reset");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        din      = 1'b0;
        odd_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("por");
        rst = 1'b0;
        idle(2);

        // Directed frames
        send_frame(3'b111, 0, 1, 0);
        idle(1);
        send_frame(3'b011, 1, 1, 0);
        idle(1);
        send_frame(3'b011, 1, 0, 0);
        idle(2);
        send_frame(3'b101, 0, 1, 0);
        idle(1);
        send_frame(3'b001, 0, 1, 0);
        idle(6);

        // Saturation: five bad frames from a cleared counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_frame(3'b110, 0, 1, 0);
            idle(1);
        end
        idle(5);

        // start pulses while busy must be ignored
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
        send_frame(3'b100, 1, 0, 1);
        idle(6);

        // Reset after two data bits discards the frame
        @(negedge clk);
        start    = 1'b1;
        odd_mode = 1'b0;
        din      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din   = 1'b0;
        chk("busy_mid", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        din = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        check_cleared("abort");
        idle(6);
        send_frame(3'b010, 0, 1, 0);
        idle(6);

        // Back-to-back: second start in the first frame's valid cycle
        send_frame(3'b110, 0, 0, 0);
        send_frame(3'b001, 1, 0, 0);
        idle(6);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            send_frame(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 2)));
            if ($urandom_range(0, 15) == 0) do_reset();
        end

        for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk);
        chk("drain_pending", q.size(), 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
